// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the CPU data port.
// Combinational word reads, synchronous byte-enable writes and out-of-range
// protection. A post-reset clear sequence (INIT) zeroes every word before the
// RAM accepts CPU writes (RUN).
// Optional build macro: DMEM_MISALIGN_CHECK_EN enables the sticky
// misalignment report flag err_misalign.
module dmem_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter int          IDX_W     = $clog2(MEM_WORDS),
  parameter logic [31:0] OOB_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_wdata,
  input  logic [3:0]  d_mem_wen,
  output logic [31:0] d_mem_rdata,
  output logic        init_done,
  output logic [15:0] wr_count,
  output logic        err_oob,
  output logic        err_misalign
);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [MEM_WORDS];

  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             wr_req;
  logic             wr_acc;

  // Anything at or above 4*MEM_WORDS bytes has a nonzero bit above the index.
  assign in_range = (d_mem_addr >> (IDX_W + 2)) == 32'd0;
  assign idx      = d_mem_addr[IDX_W+1:2];
  assign wr_req   = |d_mem_wen;
  // CPU writes only land once the clear sequence is over.
  assign wr_acc   = (state == RUN) && in_range && wr_req;

  // State register: reset restarts the clear sequence from INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Next state: leave INIT on the edge that clears the last word; RUN is terminal.
  always_comb begin
    state_nxt = state;
    if (state == INIT && clr_idx == IDX_W'(MEM_WORDS - 1)) state_nxt = RUN;
  end

  // Outputs: init_done tracks RUN, so it rises on the edge clearing the last word.
  always_comb begin
    init_done = (state == RUN);
    if (!in_range)         d_mem_rdata = OOB_RDATA;
    else if (state == RUN) d_mem_rdata = mem[idx];
    else                   d_mem_rdata = 32'd0;
  end

  // Clear pointer, saturating write counter and sticky out-of-range flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx  <= '0;
      wr_count <= 16'd0;
      err_oob  <= 1'b0;
    end else begin
      if (state == INIT)                     clr_idx  <= clr_idx + 1'b1;
      if (wr_acc && wr_count != 16'hFFFF)    wr_count <= wr_count + 16'd1;
      if (!in_range && wr_req)               err_oob  <= 1'b1;
    end
  end

  // Storage: not reset. INIT zeroes one word per edge, RUN applies lane writes.
  // While rst is held state is INIT with clr_idx 0, so only word 0 is rewritten
  // with zero, which the clear sequence does anyway.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_idx] <= 32'd0;
    end else if (wr_acc) begin
      for (int k = 0; k < 4; k++)
        if (d_mem_wen[k]) mem[idx][8*k +: 8] <= d_mem_wdata[8*k +: 8];
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misaligned;

  // Classify the byte-enable pattern against the address alignment it needs.
  always_comb begin
    misaligned = 1'b0;
    case (d_mem_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: misaligned = 1'b0;
      4'b0011, 4'b1100:                   misaligned = d_mem_addr[0];
      4'b1111:                            misaligned = |d_mem_addr[1:0];
      default:                            misaligned = 1'b1;
    endcase
  end

  // Sticky report-only flag, evaluated in both INIT and RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err_misalign <= 1'b0;
    else if (wr_req && misaligned)    err_misalign <= 1'b1;
  end
`else
  assign err_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed, table-driven bench for dmem_responder.
// Covers reset state, INIT length and restart, INIT write drop, byte-lane
// writes, read-during-write, out-of-range handling, wr_count saturation and
// the optional misalignment flag (DMEM_MISALIGN_CHECK_EN).
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_wen;
  logic [31:0] d_mem_rdata;
  logic        init_done;
  logic [15:0] wr_count;
  logic        err_oob;
  logic        err_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .d_mem_addr   (d_mem_addr),
    .d_mem_wdata  (d_mem_wdata),
    .d_mem_wen    (d_mem_wen),
    .d_mem_rdata  (d_mem_rdata),
    .init_done    (init_done),
    .wr_count     (wr_count),
    .err_oob      (err_oob),
    .err_misalign (err_misalign)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
    logic [31:0] rd;   // rdata before the edge (pre-write contents)
    logic [15:0] wc;   // wr_count after the edge
    logic        oob;  // err_oob after the edge
    logic        mis;  // err_misalign after the edge when the check is built in
  } vec_t;

  vec_t tv[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    int bad;

    tv[0]  = '{32'h200,      32'h0,        4'h0, 32'h0,        16'd0, 1'b0, 1'b0};
    tv[1]  = '{32'h000,      32'h0,        4'h0, 32'h0,        16'd0, 1'b0, 1'b0};
    tv[2]  = '{32'h224,      32'h37,       4'hF, 32'h0,        16'd1, 1'b0, 1'b0};
    tv[3]  = '{32'h224,      32'h0,        4'h0, 32'h37,       16'd1, 1'b0, 1'b0};
    tv[4]  = '{32'h200,      32'h11223344, 4'hF, 32'h0,        16'd2, 1'b0, 1'b0};
    tv[5]  = '{32'h200,      32'hAABBCCDD, 4'h5, 32'h11223344, 16'd3, 1'b0, 1'b1};
    tv[6]  = '{32'h200,      32'h0,        4'h0, 32'h11BB33DD, 16'd3, 1'b0, 1'b1};
    tv[7]  = '{32'h1000,     32'h0,        4'h0, 32'hDEADBEEF, 16'd3, 1'b0, 1'b1};
    tv[8]  = '{32'h1000,     32'h5,        4'hF, 32'hDEADBEEF, 16'd3, 1'b1, 1'b1};
    tv[9]  = '{32'h000,      32'h0,        4'h0, 32'h0,        16'd3, 1'b1, 1'b1};
    tv[10] = '{32'hFFC,      32'h9A000000, 4'h8, 32'h0,        16'd4, 1'b1, 1'b1};
    tv[11] = '{32'hFFE,      32'h0,        4'h0, 32'h9A000000, 16'd4, 1'b1, 1'b1};
    tv[12] = '{32'h205,      32'h00005500, 4'h2, 32'h0,        16'd5, 1'b1, 1'b1};
    tv[13] = '{32'h204,      32'h0,        4'h0, 32'h00005500, 16'd5, 1'b1, 1'b1};
    tv[14] = '{32'h7FFFFFFC, 32'h1,        4'hF, 32'hDEADBEEF, 16'd5, 1'b1, 1'b1};
    tv[15] = '{32'h200,      32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 16'd5, 1'b1, 1'b1};
    tv[16] = '{32'h202,      32'hCAFEF00D, 4'hF, 32'h11BB33DD, 16'd6, 1'b1, 1'b1};
    tv[17] = '{32'h200,      32'h0,        4'h0, 32'hCAFEF00D, 16'd6, 1'b1, 1'b1};
    tv[18] = '{32'h224,      32'h0,        4'h0, 32'h37,       16'd6, 1'b1, 1'b1};

    // Reset state
    rst = 1'b1; d_mem_addr = 32'h200; d_mem_wdata = 32'h0; d_mem_wen = 4'h0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_wr_count",  32'(wr_count),  32'd0);
    chk("rst_err_oob",   32'(err_oob),   32'd0);
    chk("rst_err_mis",   32'(err_misalign), 32'd0);
    chk("rst_rdata_200", d_mem_rdata, 32'h0);
    d_mem_addr = 32'h1000; #1;
    chk("rst_rdata_oob", d_mem_rdata, 32'hDEADBEEF);

    // First INIT: out-of-range write still flags, then reset at cycle 500
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1; d_mem_addr = 32'h1000; d_mem_wdata = 32'h5; d_mem_wen = 4'hF;
    @(posedge clk);
    #1; d_mem_wen = 4'h0;
    chk("init_oob_flag", 32'(err_oob),  32'd1);
    chk("init_oob_wc",   32'(wr_count), 32'd0);
    repeat (495) @(posedge clk);
    #1;
    chk("init_500_done", 32'(init_done), 32'd0);
    rst = 1'b1; #1;
    chk("async_rst_oob", 32'(err_oob), 32'd0);
    repeat (3) @(posedge clk);

    // Second INIT: full length, reads return 0, write at cycle 10 dropped
    @(negedge clk); rst = 1'b0;
    n = 0; bad = 0;
    while (!init_done && n < 3000) begin
      @(posedge clk);
      #1; n++;
      if (n == 9) begin
        d_mem_addr = 32'h200; d_mem_wdata = 32'h12345678; d_mem_wen = 4'hF;
      end else begin
        d_mem_wen = 4'h0;
        case (n % 3)
          0:       d_mem_addr = 32'h000;
          1:       d_mem_addr = 32'h200;
          default: d_mem_addr = 32'hFFC;
        endcase
      end
      #1;
      if (d_mem_rdata !== 32'h0) bad++;
    end
    d_mem_wen = 4'h0;
    chk("init_cycles",     32'(n),   32'd1024);
    chk("init_rdata_zero", 32'(bad), 32'd0);
    chk("init_drop_wc",    32'(wr_count), 32'd0);

    // RUN: table-driven vectors
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      d_mem_addr = tv[i].addr; d_mem_wdata = tv[i].wdata; d_mem_wen = tv[i].wen;
      #1;
      chk($sformatf("v%0d_rdata", i), d_mem_rdata, tv[i].rd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wc", i),  32'(wr_count), 32'(tv[i].wc));
      chk($sformatf("v%0d_oob", i), 32'(err_oob),  32'(tv[i].oob));
      chk($sformatf("v%0d_mis", i), 32'(err_misalign), 32'(tv[i].mis & MIS_EN));
    end

    // wr_count saturation
    @(negedge clk);
    d_mem_addr = 32'h10; d_mem_wdata = 32'hA5; d_mem_wen = 4'h1;
    repeat (65535) @(posedge clk);
    #1; d_mem_wen = 4'h0;
    chk("wc_saturate", 32'(wr_count), 32'h0000FFFF);
    @(negedge clk);
    d_mem_addr = 32'h10; #1;
    chk("sat_rdata", d_mem_rdata, 32'h000000A5);

    // Asynchronous reset from RUN clears everything before any edge
    @(negedge clk); rst = 1'b1; d_mem_addr = 32'h224; #1;
    chk("run_rst_done",  32'(init_done), 32'd0);
    chk("run_rst_wc",    32'(wr_count),  32'd0);
    chk("run_rst_oob",   32'(err_oob),   32'd0);
    chk("run_rst_mis",   32'(err_misalign), 32'd0);
    chk("run_rst_rdata", d_mem_rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
